// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin grant arbiter.
// Holds sizes, the FSM state enum and the rotating search function.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req, scanning upward from start and wrapping.
  function automatic pick_t next_rr(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] start
  );
    pick_t            p;
    logic [IDX_W-1:0] j;
    p = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = start + IDX_W'(k);
      if (!p.found && req[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/idx_to_onehot8.sv
// 3-bit index to 8-bit one-hot expansion.
// Output is all zero while en is low.
module idx_to_onehot8
  import rr_arb_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] oh
);

  // Decode the index into a single set bit
  always_comb begin
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (en && idx == IDX_W'(i)) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter for eight clients with registered grant and an
// optional hold limit that rotates a long-running owner out.
module rr_grant_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int HOLD_W =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? HOLD_W'(1) : HOLD_W'(MAX_HOLD);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  others;
  pick_t             p;

  // Next grant: new pick from idle, release, forced rotation or hold
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    p       = '0;
    others  = req & ~(N_REQ'(1) << idx_q);
    unique case (state_q)
      IDLE: begin
        p = next_rr(req, last_q + IDX_W'(1));
        if (p.found) begin
          state_d = GRANT;
          idx_d   = p.idx;
          last_d  = p.idx;
          valid_d = 1'b1;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          p = next_rr(req, idx_q + IDX_W'(1));
          if (p.found) begin
            idx_d  = p.idx;
            last_d = p.idx;
            hold_d = HOLD_W'(1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (MAX_HOLD != 0 && hold_q == HOLD_LIM
                     && |others) begin
          p      = next_rr(others, idx_q + IDX_W'(1));
          idx_d  = p.idx;
          last_d = p.idx;
          hold_d = HOLD_W'(1);
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

  idx_to_onehot8 u_oh (
    .en  (valid_q),
    .idx (idx_q),
    .oh  (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Bench for rr_grant_arbiter8: directed scenarios plus random traffic
// checked every cycle against a behavioural round-robin model.
module tb_rr_grant_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_cmp = 0;
  int n_bad = 0;

  rr_grant_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // model: owner (-1 = nobody), pointer, cycles in current tenure
  int m_own = -1;
  int m_last = 7;
  int m_ten = 0;
  bit chk_en = 1'b0;

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++)
      if (r[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) t=%0t",
               nm, got, got, want, want, $time);
    end
  endtask

  // reference model advances on each rising edge
  always @(posedge clk) begin : model
    int w;
    logic [7:0] oth;
    if (rst) begin
      m_own = -1; m_last = 7; m_ten = 0;
    end else if (m_own < 0) begin
      w = pick(req, m_last);
      if (w >= 0) begin m_own = w; m_last = w; m_ten = 1; end
    end else if (!req[m_own]) begin
      w = pick(req, m_own);
      if (w >= 0) begin m_own = w; m_last = w; m_ten = 1; end
      else m_own = -1;
    end else begin
      oth = req & ~(8'h01 << m_own);
      if (MH != 0 && m_ten >= MH && oth != 8'h00) begin
        w = pick(oth, m_own);
        m_own = w; m_last = w; m_ten = 1;
      end else begin
        m_ten++;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin : cmp
    if (chk_en) begin
      check("gnt", int'(gnt),
            (m_own >= 0) ? (1 << m_own) : 0);
      check("gnt_valid", int'(gnt_valid), (m_own >= 0) ? 1 : 0);
      if (m_own >= 0) check("gnt_idx", int'(gnt_idx), m_own);
    end
  end

  task automatic tick(input logic [7:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int seq[$];
    int prev, hc, bub;
    logic [7:0] r;

    // 1: reset, idle, then single request
    tick(8'h00, 1'b1);
    chk_en = 1'b1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_idx", int'(gnt_idx), 0);
    check("rst_valid", int'(gnt_valid), 0);
    repeat (5) begin
      tick(8'h00, 1'b0);
      check("idle_gnt", int'(gnt), 0);
      check("idle_valid", int'(gnt_valid), 0);
    end
    tick(8'h10, 1'b0);
    check("t1_gnt", int'(gnt), 'h10);
    check("t1_idx", int'(gnt_idx), 4);
    check("t1_model", m_own, 4);

    // 2: all requesting, owner drops after 2 held cycles
    tick(8'h00, 1'b1);
    prev = -1; hc = 0; bub = 0; r = 8'hFF;
    for (int c = 0; c < 60 && seq.size() < 9; c++) begin
      tick(r, 1'b0);
      if (gnt_valid) begin
        if (int'(gnt_idx) != prev) begin
          seq.push_back(int'(gnt_idx));
          hc = 1;
        end else hc++;
        prev = int'(gnt_idx);
      end else if (seq.size() > 0) bub++;
      r = (gnt_valid && hc >= 2) ? (8'hFF & ~(8'h01 << gnt_idx))
                                 : 8'hFF;
    end
    check("t2_len", seq.size(), 9);
    for (int i = 0; i < seq.size(); i++)
      check("t2_seq", seq[i], i % 8);
    check("t2_bubble", bub, 0);

    // 3: forced rotation at MH, then lone owner saturates
    tick(8'h00, 1'b1);
    for (int i = 0; i < 24; i++) begin
      tick(8'h03, 1'b0);
      check("t3_idx", int'(gnt_idx), (i / MH) % 2);
      check("t3_valid", int'(gnt_valid), 1);
    end
    tick(8'h00, 1'b1);
    for (int i = 0; i < 24; i++) begin
      tick(8'h01, 1'b0);
      check("t3_solo", int'(gnt), 1);
    end

    // 4: pointer wrap 7 -> 0
    tick(8'h00, 1'b1);
    tick(8'h40, 1'b0);
    check("t4_idx6", int'(gnt_idx), 6);
    tick(8'h00, 1'b0);
    check("t4_idle", int'(gnt_valid), 0);
    tick(8'h41, 1'b0);
    check("t4_wrap", int'(gnt_idx), 0);
    check("t4_gnt", int'(gnt), 1);

    // 5: reset mid-grant loses history
    tick(8'h00, 1'b1);
    tick(8'h20, 1'b0);
    tick(8'h20, 1'b0);
    check("t5_idx5", int'(gnt_idx), 5);
    tick(8'h21, 1'b1);
    check("t5_rst_gnt", int'(gnt), 0);
    check("t5_rst_valid", int'(gnt_valid), 0);
    tick(8'h21, 1'b0);
    check("t5_after", int'(gnt_idx), 0);
    check("t5_model", m_own, 0);

    // 6: release to idle, and release with handoff
    tick(8'h00, 1'b1);
    tick(8'h08, 1'b0);
    check("t6_idx3", int'(gnt_idx), 3);
    tick(8'h00, 1'b0);
    check("t6_idle_gnt", int'(gnt), 0);
    check("t6_idle_valid", int'(gnt_valid), 0);
    tick(8'h08, 1'b0);
    tick(8'h04, 1'b0);
    check("t6_handoff", int'(gnt), 'h04);

    // random traffic with sticky patterns and rare resets
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom());
      else if ($urandom_range(0, 3) == 0)
        r = r ^ (8'h01 << $urandom_range(0, 7));
      tick(r, ($urandom_range(0, 99) == 0));
    end
    tick(8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
